// File: rtl/spart_tx.sv
// SPART transmitter: one-entry holding buffer feeding an 8N1 serializer paced by 16x Baud ticks.
// TxD/TBR/busy are registered; a held byte follows the previous stop bit with no idle gap.
module spart_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Baud,
  input  logic [DATA_BITS-1:0] TxD_data,
  input  logic                 load,
  output logic                 TxD,
  output logic                 TBR,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] hold_reg, hold_reg_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic                 hold_valid, hold_valid_nxt;
  logic [TW-1:0]        tick_cnt, tick_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic                 txd_nxt;
  logic                 bit_end;
  logic                 xfer;

  assign bit_end = Baud && (tick_cnt == TICK_LAST);
  // A held byte moves to the shifter from idle, or right as a stop bit completes.
  assign xfer    = hold_valid && ((state == IDLE) || ((state == STOP) && bit_end));

  always_comb begin
    state_nxt      = state;
    hold_reg_nxt   = hold_reg;
    hold_valid_nxt = hold_valid;
    shift_nxt      = shift_reg;
    tick_nxt       = tick_cnt;
    bit_nxt        = bit_cnt;
    txd_nxt        = 1'b1;

    if (load && !hold_valid) begin
      hold_reg_nxt   = TxD_data;
      hold_valid_nxt = 1'b1;
    end

    if ((state != IDLE) && Baud)
      tick_nxt = bit_end ? '0 : tick_cnt + 1'b1;

    case (state)
      IDLE: ;
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt = shift_reg >> 1;
          bit_nxt   = bit_cnt + 1'b1;
          if (bit_nxt == BIT_LAST)
            state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (xfer) begin
      shift_nxt      = hold_reg;
      hold_valid_nxt = 1'b0;
      state_nxt      = START;
      tick_nxt       = '0;
      bit_nxt        = '0;
    end

    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift_nxt[0];
      default: txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold_reg   <= '0;
      hold_valid <= 1'b0;
      shift_reg  <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      TxD        <= 1'b1;
      TBR        <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_reg   <= hold_reg_nxt;
      hold_valid <= hold_valid_nxt;
      shift_reg  <= shift_nxt;
      tick_cnt   <= tick_nxt;
      bit_cnt    <= bit_nxt;
      TxD        <= txd_nxt;
      TBR        <= ~hold_valid_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: doc/spart_tx.md
Name: spart_tx

Overview:
- UART transmit stage of the mini SPART; the serial counterpart of the receive path.
- Accepts a byte from the bus-side interface into a one-entry holding buffer and serializes it on TxD as 8N1: start bit, 8 data bits LSB first, one stop bit.
- Bit timing uses the same 16x oversampled Baud enable pulse that the receiver consumes. The holding buffer allows back-to-back frames with no idle gap.

Parameters:
- OVERSAMPLE, 16, Baud ticks per serial bit (>= 2).
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-low reset: 0 resets the block immediately, independent of clk.
- Baud  input  1  one-clk-wide enable pulse at OVERSAMPLE x bit rate.
- TxD_data  input  DATA_BITS  byte to transmit; sampled only on an accepted load.
- load  input  1  write strobe; accepted only when TBR=1.
- TxD  output  1  serial line, registered; idles high.
- TBR  output  1  transmit buffer ready (holding buffer empty).
- busy  output  1  high while a frame (start..stop) is on the line.

Behaviour:
- Reset (rst=0, async):
  - TxD=1, TBR=1, busy=0.
  - State=IDLE; hold_valid=0; shift register, bit counter and tick counter cleared.
- Holding buffer and TBR:
  - TBR = ~hold_valid.
  - load & TBR: capture TxD_data into hold_reg; hold_valid=1 next cycle.
  - load & ~TBR: ignored. hold_reg, shift register and the line are unaffected; no error flag.
- Transfer from holding to shift register:
  - Occurs when hold_valid=1 and either (a) state=IDLE, or (b) in STOP on the cycle the stop-bit period ends.
  - On transfer: hold_reg -> shift_reg; hold_valid clears that same cycle; state -> START; tick and bit counters reset.
  - load and transfer can never coincide: load needs hold_valid=0, transfer needs 1.
- State machine:
  - IDLE: TxD=1. Leaves on transfer.
  - START: TxD=0 for OVERSAMPLE Baud ticks, then -> DATA.
  - DATA: TxD=shift_reg[0]. After each OVERSAMPLE ticks, shift right and bit_cnt++. When bit_cnt reaches DATA_BITS -> STOP.
  - STOP: TxD=1 for OVERSAMPLE ticks. At period end: transfer if hold_valid, else -> IDLE.
- Bit timing:
  - tick_cnt counts Baud pulses from 0.
  - A bit period ends on the clk edge where Baud=1 and tick_cnt==OVERSAMPLE-1; tick_cnt then wraps to 0.
  - Cycles with Baud=0 hold all state. If Baud is stalled, TxD holds its current bit indefinitely.
  - Frame length = (DATA_BITS+2)*OVERSAMPLE Baud ticks = 160 at defaults.
- Latency and registered outputs:
  - Load accepted at edge N from IDLE: TBR=0 after N; transfer at N+1, so TBR=1 and TxD=0 after N+1.
  - TxD, TBR and busy are registered; no combinational path from inputs to outputs.
- busy: 1 in START/DATA/STOP. Stays 1 continuously across back-to-back frames.
- Widths: tick_cnt is clog2(OVERSAMPLE) bits; bit_cnt is clog2(DATA_BITS+1) bits. No overflow is reachable.
- Reset mid-frame: the line returns to 1 immediately (async). Any held byte is discarded; TBR=1.

Test Plan:
- Reset: rst=0 with load=1, Baud toggling -> TxD=1, TBR=1, busy=0 throughout; a load issued during reset is not captured.
- Single byte, Baud=1 every cycle: load 0xA5 -> TxD sequence 0,1,0,1,0,0,1,0,1,1, each held exactly 16 cycles; busy high 160 cycles; TBR low exactly 1 cycle.
- Back-to-back: load 0x55, then load 0x0F mid-frame -> TBR=0 until the 0x55 stop bit ends. The 0x0F start bit follows the stop bit with zero idle cycles; busy never drops.
- Overrun: while TBR=0, pulse load with 0xFF -> ignored; the line still carries the previously held byte.
- Baud gating: Baud every 4th cycle, load 0x3C -> each bit lasts 64 clk cycles. Stall Baud for 100 cycles mid-bit -> TxD frozen; the frame resumes with the correct remaining bits.
- Reset mid-frame: assert rst during data bit 3 with hold_valid=1 -> TxD=1 and TBR=1 without waiting for a clk edge; after release, no residual frame is sent.
